// File: rtl/tf_pin_pkg.sv
// Shared constants for the TT-pin host byte responder: opcodes, FSM states, pin bit positions.
package tf_pin_pkg;

    localparam logic [3:0] OP_WR    = 4'h1;
    localparam logic [3:0] OP_RD    = 4'h2;
    localparam logic [7:0] OP_START = 8'h30;
    localparam logic [7:0] OP_STAT  = 8'h40;
    localparam logic [7:0] OP_CLR   = 8'h50;

    localparam int REQ_BIT = 0;
    localparam int ACK_BIT = 1;
    localparam int ERR_BIT = 2;

    localparam logic [7:0] UIO_OE_MASK = 8'b0000_0110;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_ACK  = 1'b1
    } tf_state_e;

endpackage

// File: rtl/tf_req_sync.sv
// Two-flop synchroniser for the host req line; only built when TF_REQ_SYNC_EN is defined,
// since the direct-connect build has no asynchronous input to protect.
`ifdef TF_REQ_SYNC_EN
module tf_req_sync (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta <= 1'b0;
            q    <= 1'b0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule
`endif

// File: rtl/tf_pin_responder.sv
// Device-side responder for the 4-phase host byte protocol on the TT pins.
// Optional macro TF_REQ_SYNC_EN routes req through a 2-flop synchroniser.
//
//  state   | meaning
//  ST_IDLE | waiting for req; a seen req executes the byte and raises ack
//  ST_ACK  | ack held high until the host drops req
module tf_pin_responder
    import tf_pin_pkg::*;
#(
    parameter int NREG = 4,
    parameter int NRES = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              ena,
    input  logic [7:0]        ui_in,
    input  logic [7:0]        uio_in,
    output logic [7:0]        uo_out,
    output logic [7:0]        uio_out,
    output logic [7:0]        uio_oe,
    output logic [NREG*8-1:0] cfg_regs,
    output logic              start,
    input  logic              busy_in,
    input  logic [NRES*8-1:0] res_regs
);

    tf_state_e            state_q, state_d;
    logic                 err_q, err_d;
    logic [7:0]           uo_q, uo_d;
    logic                 pend_q, pend_d;
    logic [3:0]           pend_addr_q, pend_addr_d;
    logic [NREG-1:0][7:0] cfg_q, cfg_d;
    logic                 start_q, start_d;
    logic                 req_s;
    logic [7:0]           rd_data;
    logic                 rd_hit;
    logic                 wr_hit;
    logic                 unused_uio;

`ifdef TF_REQ_SYNC_EN
    tf_req_sync u_req_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (uio_in[REQ_BIT]),
        .q     (req_s)
    );
`else
    assign req_s = uio_in[REQ_BIT];
`endif

    assign unused_uio = ^uio_in[7:1];

    // Read mux over cfg and result space; anything past NREG+NRES reads as zero.
    always_comb begin
        rd_data = 8'h00;
        rd_hit  = 1'b0;
        wr_hit  = 1'b0;
        for (int i = 0; i < NREG; i++) begin
            if (ui_in[3:0] == 4'(i)) begin
                rd_data = cfg_q[i];
                rd_hit  = 1'b1;
            end
            if (pend_addr_q == 4'(i)) begin
                wr_hit = 1'b1;
            end
        end
        for (int j = 0; j < NRES; j++) begin
            if (ui_in[3:0] == 4'(NREG + j)) begin
                rd_data = res_regs[8*j +: 8];
                rd_hit  = 1'b1;
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        err_d       = err_q;
        uo_d        = uo_q;
        pend_d      = pend_q;
        pend_addr_d = pend_addr_q;
        cfg_d       = cfg_q;
        start_d     = 1'b0;
        if (!ena) begin
            state_d = ST_IDLE;
            pend_d  = 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (req_s) begin
                        state_d = ST_ACK;
                        if (pend_q) begin
                            // Data byte of a write: never decoded as an opcode.
                            pend_d = 1'b0;
                            if (wr_hit) begin
                                for (int i = 0; i < NREG; i++) begin
                                    if (pend_addr_q == 4'(i)) begin
                                        cfg_d[i] = ui_in;
                                    end
                                end
                            end else begin
                                err_d = 1'b1;
                            end
                        end else if (ui_in[7:4] == OP_WR) begin
                            pend_d      = 1'b1;
                            pend_addr_d = ui_in[3:0];
                        end else if (ui_in[7:4] == OP_RD) begin
                            uo_d = rd_data;
                            if (!rd_hit) begin
                                err_d = 1'b1;
                            end
                        end else if (ui_in == OP_START) begin
                            if (busy_in) begin
                                err_d = 1'b1;
                            end else begin
                                start_d = 1'b1;
                            end
                        end else if (ui_in == OP_STAT) begin
                            uo_d = {6'b0, err_q, busy_in};
                        end else if (ui_in == OP_CLR) begin
                            err_d = 1'b0;
                        end else begin
                            err_d = 1'b1;
                        end
                    end
                end
                ST_ACK: begin
                    if (!req_s) begin
                        state_d = ST_IDLE;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            err_q       <= 1'b0;
            uo_q        <= 8'h00;
            pend_q      <= 1'b0;
            pend_addr_q <= 4'h0;
            cfg_q       <= '0;
            start_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            err_q       <= err_d;
            uo_q        <= uo_d;
            pend_q      <= pend_d;
            pend_addr_q <= pend_addr_d;
            cfg_q       <= cfg_d;
            start_q     <= start_d;
        end
    end

    // Ack is the ACK state itself, so an async reset drops it without waiting for a clock.
    always_comb begin
        uio_out          = 8'h00;
        uio_out[ACK_BIT] = (state_q == ST_ACK);
        uio_out[ERR_BIT] = err_q;
    end

    assign uio_oe   = UIO_OE_MASK;
    assign uo_out   = uo_q;
    assign cfg_regs = cfg_q;
    assign start    = start_q;

endmodule

// File: tb/tb_tf_pin_responder.sv
// Self-checking bench for tf_pin_responder: transaction-level model plus directed handshakes.
module tb_tf_pin_responder;

    localparam int NREG = 4;
    localparam int NRES = 4;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              ena = 1'b1;
    logic [7:0]        ui_in = 8'h00;
    logic [7:0]        uio_in = 8'h00;
    logic [7:0]        uo_out;
    logic [7:0]        uio_out;
    logic [7:0]        uio_oe;
    logic [NREG*8-1:0] cfg_regs;
    logic              start;
    logic              busy_in = 1'b0;
    logic [NRES*8-1:0] res_regs = 32'h1122_3C44;

    int total = 0;
    int bad = 0;
    int start_cnt = 0;
    logic ack_start;

    tf_pin_responder #(.NREG(NREG), .NRES(NRES)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .ena      (ena),
        .ui_in    (ui_in),
        .uio_in   (uio_in),
        .uo_out   (uo_out),
        .uio_out  (uio_out),
        .uio_oe   (uio_oe),
        .cfg_regs (cfg_regs),
        .start    (start),
        .busy_in  (busy_in),
        .res_regs (res_regs)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Protocol model: handshake flag plus register/err/readback state.
    logic [NREG-1:0][7:0] m_cfg = '0;
    logic       m_err = 1'b0;
    logic       m_pend = 1'b0;
    logic [3:0] m_pa = 4'h0;
    logic [7:0] m_uo = 8'h00;
    logic       m_ack = 1'b0;
    logic       m_start = 1'b0;
`ifdef TF_REQ_SYNC_EN
    logic       m_r1 = 1'b0;
    logic       m_r2 = 1'b0;
`endif

    task automatic model_byte(input logic [7:0] b);
        int n;
        n = int'(b[3:0]);
        if (m_pend) begin
            m_pend = 1'b0;
            if (int'(m_pa) < NREG) begin
                for (int i = 0; i < NREG; i++)
                    if (i == int'(m_pa)) m_cfg[i] = b;
            end else begin
                m_err = 1'b1;
            end
        end else if (b >= 8'h10 && b <= 8'h1F) begin
            m_pend = 1'b1;
            m_pa = b[3:0];
        end else if (b >= 8'h20 && b <= 8'h2F) begin
            if (n < NREG) m_uo = m_cfg[n];
            else if (n < NREG + NRES) m_uo = 8'((res_regs >> (8 * (n - NREG))) & 32'hFF);
            else begin
                m_uo = 8'h00;
                m_err = 1'b1;
            end
        end else if (b == 8'h30) begin
            if (busy_in) m_err = 1'b1;
            else m_start = 1'b1;
        end else if (b == 8'h40) begin
            m_uo = 8'(int'(m_err) * 2 + int'(busy_in));
        end else if (b == 8'h50) begin
            m_err = 1'b0;
        end else begin
            m_err = 1'b1;
        end
    endtask

    initial forever begin
        @(posedge clk or negedge rst_n);
        if (!rst_n) begin
            m_cfg = '0; m_err = 1'b0; m_pend = 1'b0; m_pa = 4'h0;
            m_uo = 8'h00; m_ack = 1'b0; m_start = 1'b0;
`ifdef TF_REQ_SYNC_EN
            m_r1 = 1'b0; m_r2 = 1'b0;
`endif
        end else begin
            logic req_now;
`ifdef TF_REQ_SYNC_EN
            req_now = m_r2;
            m_r2 = m_r1;
            m_r1 = uio_in[0];
`else
            req_now = uio_in[0];
`endif
            m_start = 1'b0;
            if (!ena) begin
                m_ack = 1'b0;
                m_pend = 1'b0;
            end else if (!m_ack && req_now) begin
                m_ack = 1'b1;
                model_byte(ui_in);
            end else if (m_ack && !req_now) begin
                m_ack = 1'b0;
            end
        end
    end

    initial forever begin
        @(negedge clk);
        if (rst_n) begin
            check("uo_out", {24'h0, uo_out}, {24'h0, m_uo});
            check("uio_out", {24'h0, uio_out}, {24'h0, 5'b0, m_err, m_ack, 1'b0});
            check("uio_oe", {24'h0, uio_oe}, 32'h06);
            check("start", {31'h0, start}, {31'h0, m_start});
            check("cfg_regs", cfg_regs, m_cfg);
            if (start) start_cnt++;
        end
    end

    task automatic req_up(input logic [7:0] b);
        int n;
        @(negedge clk);
        ui_in = b;
        uio_in[0] = 1'b1;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!uio_out[1] && n < 8);
        ack_start = start;
        if (!uio_out[1]) check("ack_rise_timeout", {31'h0, uio_out[1]}, 32'h1);
    endtask

    task automatic req_down();
        int n;
        uio_in[0] = 1'b0;
        ui_in = 8'hEE;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (uio_out[1] && n < 8);
        if (uio_out[1]) check("ack_fall_timeout", {31'h0, uio_out[1]}, 32'h0);
    endtask

    task automatic send(input logic [7:0] b);
        req_up(b);
        req_down();
    endtask

    initial begin
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("rst_uo_out", {24'h0, uo_out}, 32'h00);
        check("rst_uio_out", {24'h0, uio_out}, 32'h00);
        check("rst_uio_oe", {24'h0, uio_oe}, 32'h06);
        check("rst_cfg", cfg_regs, 32'h0);

        send(8'h12); send(8'hA5); send(8'h22);
        check("cfg2_written", {24'h0, cfg_regs[23:16]}, 32'hA5);
        check("rd_reg2", {24'h0, uo_out}, 32'hA5);
        check("err_after_wr", {31'h0, uio_out[2]}, 32'h0);

        send(8'h25);
        check("rd_res1", {24'h0, uo_out}, 32'h3C);
        send(8'h2F);
        check("rd_oob_data", {24'h0, uo_out}, 32'h00);
        check("rd_oob_err", {31'h0, uio_out[2]}, 32'h1);

        send(8'h50);
        check("clr_err", {31'h0, uio_out[2]}, 32'h0);
        busy_in = 1'b0;
        req_up(8'h30);
        check("start_at_ack", {31'h0, ack_start}, 32'h1);
        req_down();
        check("start_count", start_cnt, 1);
        busy_in = 1'b1;
        send(8'h30);
        check("start_busy_count", start_cnt, 1);
        check("start_busy_err", {31'h0, uio_out[2]}, 32'h1);
        send(8'h40);
        check("status_busy_err", {24'h0, uo_out}, 32'h03);
        busy_in = 1'b0;

        send(8'h50); send(8'h77);
        check("bad_op_err", {31'h0, uio_out[2]}, 32'h1);
        send(8'h50);
        check("clr_after_bad", {31'h0, uio_out[2]}, 32'h0);
        send(8'h40);
        check("status_clean", {24'h0, uo_out}, 32'h00);
        send(8'h50);
        check("clr_noop", {31'h0, uio_out[2]}, 32'h0);

        send(8'h17); send(8'h5A);
        check("wr_oob_err", {31'h0, uio_out[2]}, 32'h1);
        check("wr_oob_nowrite", cfg_regs, 32'h00A5_0000);
        send(8'h40);
        check("status_err_only", {24'h0, uo_out}, 32'h02);
        send(8'h50);

        req_up(8'h11);
        @(negedge clk);
        ena = 1'b0;
        @(negedge clk);
        check("ena_drop_ack", {31'h0, uio_out[1]}, 32'h0);
        uio_in[0] = 1'b0;
        @(negedge clk);
        ena = 1'b1;
        send(8'h99);
        check("ena_pend_cleared", {24'h0, cfg_regs[15:8]}, 32'h00);
        check("ena_99_is_opcode", {31'h0, uio_out[2]}, 32'h1);
        send(8'h50);

        req_up(8'h13);
        check("ack_before_rst", {31'h0, uio_out[1]}, 32'h1);
        #1 rst_n = 1'b0;
        #1 check("ack_async_drop", {31'h0, uio_out[1]}, 32'h0);
        uio_in[0] = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("rst2_cfg", cfg_regs, 32'h0);
        send(8'h44);
        check("post_rst_no_write", cfg_regs, 32'h0);
        check("post_rst_44_err", {31'h0, uio_out[2]}, 32'h1);
        send(8'h40);
        check("post_rst_status", {24'h0, uo_out}, 32'h02);

        repeat (3) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1);
    end

endmodule
